mul_ctrl: RTL and testbench
===========================

# mul_ctrl

Sequencing controller for the 4-stage Booth/Wallace multiplier in the EX stage. Accepts one multiply request at a time over a valid/ready handshake and latches its operands. Holds the multiplier enable high for exactly the four cycles it needs, then captures the 32-bit result and returns it over a second valid/ready handshake. Also handles pipeline flush and, optionally, reuses a just-computed 64-bit product for the other half of the same multiply.

## Interface
Parameters:
- `XLEN`, default 32: operand/result width; the multiplier depth is fixed at 4 cycles for this width.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `req_valid`, in, 1: multiply request present.
- `req_ready`, out, 1: controller can accept; high only in IDLE.
- `req_op1`, in, XLEN: multiplicand.
- `req_op2`, in, XLEN: multiplier.
- `req_sign`, in, 2: sign mode; uses the shared UNSIGNED_UNSIGNED / SIGNED_SIGNED / UNSIGNED_SIGNED codes.
- `req_high`, in, 1: 1 returns product[63:32], 0 returns product[31:0].
- `flush`, in, 1: kill any in-flight or pending request.
- `resp_valid`, out, 1: result available.
- `resp_ready`, in, 1: consumer accepts the result.
- `resp_data`, out, XLEN: registered result.
- `busy`, out, 1: state != IDLE.
- `mul_en`, out, 1: drives the multiplier's stage enable.
- `mul_word_sel`, out, 1: drives the multiplier's high/low select.
- `mul_m1`, out, XLEN: latched operand 1, stable while `mul_en` is high.
- `mul_m2`, out, XLEN: latched operand 2, stable while `mul_en` is high.
- `mul_sign`, out, 2: latched sign mode.
- `mul_done`, in, 1: multiplier completion.
- `mul_res`, in, XLEN: multiplier result, valid while `mul_done` is high.

## Operation
State machine:
- IDLE: `req_ready`=1. On `req_valid && !flush`, latch op1/op2/sign/high, then go to RUN, or to FUSE on a reuse hit.
- RUN: `mul_en`=1 and `cnt` increments each cycle.
  - On `mul_done`, capture `mul_res` into `resp_data`, set the reuse tag, and go to RESP.
  - If `cnt`==3 and `mul_done`=0, go to RESP anyway with `resp_data`=0. This is a protocol error; the bench asserts it never happens.
- FUSE: `mul_en`=0 and `mul_word_sel`=latched high. Capture `mul_res`, then go to RESP.
- RESP: `resp_valid`=1. On `resp_ready`, go to IDLE. Hold `resp_data` until the handshake completes.

Datapath rules:
- `mul_m1`/`mul_m2`/`mul_sign`/`mul_word_sel` are registers. They change only on request acceptance; `mul_word_sel` additionally changes on entry to FUSE.
- `mul_en` is never high in two consecutive operations without an intervening low cycle. This guarantees the multiplier's internal counter restarts from 0.

Flush:
- In RUN or FUSE: drop `mul_en` the next cycle, discard the result, go to IDLE, and clear the reuse tag, since the multiplier stages are partially updated.
- In RESP: drop `resp_valid` and go to IDLE; the tag is kept.
- In IDLE: ignore `req_valid` that cycle.

Simultaneous events:
- `flush` has priority over `resp_ready` and `req_valid`.

Reset values: all outputs 0, state IDLE, tag invalid. `req_ready` is 1 from the first cycle after reset deasserts.

## Timing
- Request accepted at cycle T:
  - `mul_en`=1 during T+1..T+4.
  - `mul_done` arrives at T+4.
  - `resp_valid`=1 from T+5.
- Back-to-back throughput: one multiply per 6 cycles with `resp_ready` tied high.
- Reuse hit accepted at T: FUSE at T+1, `resp_valid` at T+2.
- `resp_valid` stays high until `resp_ready`; `resp_data` must not glitch while `resp_valid` is high.

## Configuration
- `MUL_FUSE_EN` defined:
  - The tag holds {op1, op2, sign, high} of the last completed RUN.
  - A request with equal op1/op2/sign and opposite `req_high` is a hit and takes the FUSE path.
  - This relies on the multiplier holding its final-stage registers while `mul_en`=0.
- `MUL_FUSE_EN` undefined: no tag and no FUSE state; every request takes RUN.

## Structure
- Shared package/defines:
  - State encoding: IDLE, RUN, FUSE, RESP.
  - Sign-mode codes.
  - A `MUL_LATENCY`=4 constant.
- One natural sub-module: `mul_fuse_tag`, the tag register plus comparator, instantiated only under `MUL_FUSE_EN`.

## Test plan
- Unsigned 7×6, low: `resp_data`=0x0000002A, `resp_valid` exactly 5 cycles after acceptance.
- Signed 0x80000000×0x80000000, high: `resp_data`=0x40000000. Then repeat the same operands with high=0: `resp_data`=0x00000000.
  - With `MUL_FUSE_EN`, the second response comes 2 cycles after acceptance and `mul_en` stays 0.
  - Without `MUL_FUSE_EN`, it comes after 5 cycles.
- Unsigned-signed 0xFFFFFFFF×0x00000002, high: `resp_data`=0xFFFFFFFF.
- `flush` at T+2 of a RUN: `mul_en` low at T+3, no `resp_valid`, `req_ready`=1 at T+3. A following identical opposite-half request takes the full RUN path.
- Hold `resp_ready`=0 for 10 cycles: `resp_valid` and `resp_data` stay stable, `req_ready`=0 throughout. The new request is accepted the cycle after the handshake completes.
- Reset asserted mid-RUN: next cycle all outputs are 0, state IDLE.

Source files
------------

// File: rtl/mul_ctrl_pkg.sv
// Shared types and constants for the EX-stage multiply controller.
// State encoding, sign-mode codes and the fixed multiplier latency.
package mul_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FUSE = 2'd2,
        ST_RESP = 2'd3
    } mul_state_e;

    typedef logic [1:0] sign_t;

    // UNSIGNED_SIGNED follows mulhsu: op1 signed, op2 unsigned.
    localparam sign_t UNSIGNED_UNSIGNED = 2'd0;
    localparam sign_t SIGNED_SIGNED     = 2'd1;
    localparam sign_t UNSIGNED_SIGNED   = 2'd2;

    localparam int MUL_LATENCY = 4;

    localparam logic [1:0] CNT_LAST = 2'(MUL_LATENCY - 1);

endpackage

// File: rtl/mul_fuse_tag.sv
// Reuse tag: remembers {op1, op2, sign, high} of the last completed RUN.
// Ports: set/clr update the tag; cmp_* is the incoming request; hit flags
// a request for the other half of the product still held in the multiplier.
module mul_fuse_tag
    import mul_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set,
    input  logic            clr,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  sign_t           sign,
    input  logic            high,
    input  logic [XLEN-1:0] cmp_op1,
    input  logic [XLEN-1:0] cmp_op2,
    input  sign_t           cmp_sign,
    input  logic            cmp_high,
    output logic            hit
);

    logic            tag_v;
    logic [XLEN-1:0] tag_op1;
    logic [XLEN-1:0] tag_op2;
    sign_t           tag_sign;
    logic            tag_high;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_v    <= 1'b0;
            tag_op1  <= '0;
            tag_op2  <= '0;
            tag_sign <= UNSIGNED_UNSIGNED;
            tag_high <= 1'b0;
        end else if (clr) begin
            tag_v <= 1'b0;
        end else if (set) begin
            tag_v    <= 1'b1;
            tag_op1  <= op1;
            tag_op2  <= op2;
            tag_sign <= sign;
            tag_high <= high;
        end
    end

    assign hit = tag_v
              && (tag_op1 == cmp_op1)
              && (tag_op2 == cmp_op2)
              && (tag_sign == cmp_sign)
              && (tag_high != cmp_high);

endmodule

// File: rtl/mul_ctrl.sv
// Sequencer for the 4-stage EX multiplier: request/response handshakes,
// operand latching, enable window, flush. Optional reuse path: MUL_FUSE_EN.
// Ports: req_* in, resp_* out, mul_* to/from the multiplier, flush, busy.
module mul_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_op1,
    input  logic [XLEN-1:0] req_op2,
    input  logic [1:0]      req_sign,
    input  logic            req_high,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy,
    output logic            mul_en,
    output logic            mul_word_sel,
    output logic [XLEN-1:0] mul_m1,
    output logic [XLEN-1:0] mul_m2,
    output logic [1:0]      mul_sign,
    input  logic            mul_done,
    input  logic [XLEN-1:0] mul_res
);

    mul_state_e state;
    logic [1:0] cnt;
    logic       hit;

`ifdef MUL_FUSE_EN
    logic tag_set;
    logic tag_clr;

    // Only a RUN that really completed leaves a usable product behind.
    assign tag_set = rst_n && (state == ST_RUN) && !flush && mul_done;
    // A flushed RUN/FUSE leaves the multiplier stages half updated.
    assign tag_clr = (state == ST_RUN || state == ST_FUSE) && flush;

    mul_fuse_tag #(
        .XLEN     (XLEN)
    ) u_tag (
        .clk      (clk),
        .rst_n    (rst_n),
        .set      (tag_set),
        .clr      (tag_clr),
        .op1      (mul_m1),
        .op2      (mul_m2),
        .sign     (mul_sign),
        .high     (mul_word_sel),
        .cmp_op1  (req_op1),
        .cmp_op2  (req_op2),
        .cmp_sign (req_sign),
        .cmp_high (req_high),
        .hit      (hit)
    );
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= 2'd0;
            req_ready    <= 1'b0;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            busy         <= 1'b0;
            mul_en       <= 1'b0;
            mul_word_sel <= 1'b0;
            mul_m1       <= '0;
            mul_m2       <= '0;
            mul_sign     <= UNSIGNED_UNSIGNED;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_valid && !flush) begin
                        mul_m1       <= req_op1;
                        mul_m2       <= req_op2;
                        mul_sign     <= req_sign;
                        mul_word_sel <= req_high;
                        cnt          <= 2'd0;
                        req_ready    <= 1'b0;
                        busy         <= 1'b1;
                        if (hit) begin
                            state <= ST_FUSE;
                        end else begin
                            state  <= ST_RUN;
                            mul_en <= 1'b1;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state     <= ST_IDLE;
                        mul_en    <= 1'b0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end else if (mul_done) begin
                        resp_data  <= mul_res;
                        state      <= ST_RESP;
                        mul_en     <= 1'b0;
                        resp_valid <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        // Multiplier missed its slot: return 0.
                        resp_data  <= '0;
                        state      <= ST_RESP;
                        mul_en     <= 1'b0;
                        resp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
`ifdef MUL_FUSE_EN
                ST_FUSE: begin
                    if (flush) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end else begin
                        // Final stage still holds the product; just reselect.
                        resp_data  <= mul_res;
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                    end
                end
`endif
                ST_RESP: begin
                    if (flush || resp_ready) begin
                        state      <= ST_IDLE;
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    mul_en     <= 1'b0;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                    req_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_ctrl.sv
// Self-checking bench for mul_ctrl with a behavioural 4-cycle multiplier
// and a request-level reference model (expected value, latency, reuse).
module tb_mul_ctrl;
    import mul_ctrl_pkg::*;

`ifdef MUL_FUSE_EN
    localparam bit FUSE = 1'b1;
`else
    localparam bit FUSE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_op1 = '0;
    logic [31:0] req_op2 = '0;
    logic [1:0]  req_sign = '0;
    logic        req_high = 1'b0;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        busy;
    logic        mul_en;
    logic        mul_word_sel;
    logic [31:0] mul_m1;
    logic [31:0] mul_m2;
    logic [1:0]  mul_sign;
    logic        mul_done;
    logic [31:0] mul_res;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mul_ctrl #(.XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op1      (req_op1),
        .req_op2      (req_op2),
        .req_sign     (req_sign),
        .req_high     (req_high),
        .flush        (flush),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .busy         (busy),
        .mul_en       (mul_en),
        .mul_word_sel (mul_word_sel),
        .mul_m1       (mul_m1),
        .mul_m2       (mul_m2),
        .mul_sign     (mul_sign),
        .mul_done     (mul_done),
        .mul_res      (mul_res)
    );

    // Full 64-bit product from plain integer arithmetic.
    function automatic logic [63:0] ref_prod(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [1:0]  s
    );
        longint x;
        longint y;
        if (s == SIGNED_SIGNED || s == UNSIGNED_SIGNED)
            x = longint'($signed(a));
        else
            x = longint'(a);
        if (s == SIGNED_SIGNED)
            y = longint'($signed(b));
        else
            y = longint'(b);
        return 64'(x * y);
    endfunction

    // Multiplier model: done on the 4th consecutive enable cycle, final
    // stage held while disabled, garbage left by an interrupted run.
    bit   [1:0]  m_cnt;
    logic [63:0] m_held = 64'hDEAD_BEEF_DEAD_BEEF;
    logic [63:0] m_prod;
    logic [63:0] m_out;

    assign m_prod   = ref_prod(mul_m1, mul_m2, mul_sign);
    assign mul_done = mul_en && (m_cnt == 2'd3);
    assign m_out    = mul_done ? m_prod : m_held;
    assign mul_res  = mul_word_sel ? m_out[63:32] : m_out[31:0];

    always @(posedge clk) begin
        if (mul_en !== 1'b1) begin
            m_cnt <= 2'd0;
        end else begin
            m_cnt  <= m_cnt + 2'd1;
            m_held <= mul_done ? m_prod : 64'hDEAD_BEEF_DEAD_BEEF;
        end
    end

    // Reference reuse tag.
    bit          rt_v = 1'b0;
    logic [31:0] rt_a;
    logic [31:0] rt_b;
    logic [1:0]  rt_s;
    logic        rt_h;

    task automatic chk(
        input string       tag,
        input logic [63:0] got,
        input logic [63:0] exp
    );
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // fl: 0 none, >0 flush at that offset after acceptance, -1 random.
    task automatic do_op(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [1:0]  s,
        input logic        h,
        input int          fl,
        input bit          fl_resp,
        input int          hold
    );
        bit          fz;
        bit          stable;
        int          lat;
        int          t;
        int          en_cnt;
        int          n;
        int          fl_at;
        logic [63:0] p;
        logic [31:0] exp_d;

        fz    = FUSE && rt_v && rt_a == a && rt_b == b
                && rt_s == s && rt_h != h;
        lat   = fz ? 2 : 5;
        p     = ref_prod(a, b, s);
        exp_d = h ? p[63:32] : p[31:0];
        fl_at = fl;
        if (fl < 0)
            fl_at = fz ? 1 : $urandom_range(1, 4);

        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("req_ready_wait", {63'd0, req_ready}, 64'd1);

        req_valid = 1'b1;
        req_op1   = a;
        req_op2   = b;
        req_sign  = s;
        req_high  = h;
        step();
        req_valid = 1'b0;
        req_op1   = $urandom;
        req_op2   = $urandom;

        chk("m1_latch", {32'd0, mul_m1}, {32'd0, a});
        t      = 1;
        en_cnt = 0;
        while (t <= 12) begin
            en_cnt += int'(mul_en === 1'b1);
            if (fl_at == t) begin
                flush = 1'b1;
                step();
                flush = 1'b0;
                chk("flush_en", {63'd0, mul_en}, 64'd0);
                chk("flush_rdy", {63'd0, req_ready}, 64'd1);
                chk("flush_rv", {63'd0, resp_valid}, 64'd0);
                rt_v = 1'b0;
                return;
            end
            if (resp_valid === 1'b1)
                break;
            step();
            t++;
        end
        chk("latency", 64'(t), 64'(lat));
        chk("resp_data", {32'd0, resp_data}, {32'd0, exp_d});
        chk("en_cycles", 64'(en_cnt), fz ? 64'd0 : 64'd4);

        if (!fz) begin
            rt_v = 1'b1;
            rt_a = a;
            rt_b = b;
            rt_s = s;
            rt_h = h;
        end

        if (fl_resp) begin
            flush = 1'b1;
            step();
            flush = 1'b0;
            chk("rflush_rv", {63'd0, resp_valid}, 64'd0);
            chk("rflush_rdy", {63'd0, req_ready}, 64'd1);
            return;
        end

        stable = 1'b1;
        repeat (hold) begin
            step();
            if (resp_valid !== 1'b1 || resp_data !== exp_d
                || req_ready !== 1'b0)
                stable = 1'b0;
        end
        if (hold > 0)
            chk("hold_stable", {63'd0, stable}, 64'd1);

        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("post_rv", {63'd0, resp_valid}, 64'd0);
        chk("post_rdy", {63'd0, req_ready}, 64'd1);
    endtask

    logic [31:0] pa [4];
    logic [31:0] pb [4];

    initial begin
        repeat (3) step();
        chk("rst_ctl",
            {58'd0, req_ready, resp_valid, busy, mul_en,
             mul_word_sel, |mul_sign}, 64'd0);
        chk("rst_data", {resp_data, mul_m1 | mul_m2}, 64'd0);
        rst_n = 1'b1;
        step();
        chk("rdy_after_rst", {63'd0, req_ready}, 64'd1);

        do_op(32'd7, 32'd6, UNSIGNED_UNSIGNED, 1'b0, 0, 0, 0);
        chk("7x6", {32'd0, resp_data}, 64'h2A);

        do_op(32'h8000_0000, 32'h8000_0000, SIGNED_SIGNED, 1'b1, 0, 0, 0);
        chk("min_sq_hi", {32'd0, resp_data}, 64'h4000_0000);
        do_op(32'h8000_0000, 32'h8000_0000, SIGNED_SIGNED, 1'b0, 0, 0, 0);
        chk("min_sq_lo", {32'd0, resp_data}, 64'h0);

        do_op(32'hFFFF_FFFF, 32'd2, UNSIGNED_SIGNED, 1'b1, 0, 0, 0);
        chk("hsu", {32'd0, resp_data}, 64'hFFFF_FFFF);

        // Flush mid-RUN invalidates the reusable product.
        do_op(32'd5, 32'd9, UNSIGNED_UNSIGNED, 1'b1, 0, 0, 0);
        do_op(32'd11, 32'd3, UNSIGNED_UNSIGNED, 1'b0, 2, 0, 0);
        do_op(32'd5, 32'd9, UNSIGNED_UNSIGNED, 1'b0, 0, 0, 0);

        do_op(32'd123, 32'hFFFF_FF00, SIGNED_SIGNED, 1'b0, 0, 0, 10);

        // Flush in RESP keeps the tag.
        do_op(32'd3, 32'hF000_0004, SIGNED_SIGNED, 1'b1, 0, 1, 0);
        do_op(32'd3, 32'hF000_0004, SIGNED_SIGNED, 1'b0, 0, 0, 0);

        // Flush in IDLE swallows the request.
        req_valid = 1'b1;
        flush     = 1'b1;
        step();
        req_valid = 1'b0;
        flush     = 1'b0;
        chk("idle_flush", {62'd0, busy, mul_en}, 64'd0);
        step();
        chk("idle_flush2", {62'd0, busy, req_ready}, 64'd1);

        // Reset mid-RUN.
        req_valid = 1'b1;
        req_op1   = 32'd7;
        req_op2   = 32'd8;
        req_sign  = UNSIGNED_UNSIGNED;
        req_high  = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        chk("rst_run_ctl",
            {58'd0, req_ready, resp_valid, busy, mul_en,
             mul_word_sel, |mul_sign}, 64'd0);
        chk("rst_run_data", {resp_data, mul_m1 | mul_m2}, 64'd0);
        rst_n = 1'b1;
        rt_v  = 1'b0;
        step();
        chk("rst_run_rdy", {63'd0, req_ready}, 64'd1);

        pa[0] = 32'h8000_0000; pb[0] = 32'h8000_0000;
        pa[1] = 32'hFFFF_FFFF; pb[1] = 32'd2;
        pa[2] = $urandom;      pb[2] = $urandom;
        pa[3] = $urandom;      pb[3] = $urandom;
        for (int i = 0; i < 120; i++) begin
            int k;
            int fl;
            k  = $urandom_range(0, 3);
            fl = ($urandom_range(0, 9) == 0) ? -1 : 0;
            do_op(pa[k], pb[k], 2'($urandom_range(0, 2)),
                  1'($urandom_range(0, 1)), fl,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
